// File: rtl/kronos_types.sv
// Shared types and helpers for the Kronos data-bus peripherals.
package kronos_types;

  // Machine-timer register offsets (data_addr[4:2])
  localparam logic [2:0] MTIMER_MTIME_LO = 3'd0;
  localparam logic [2:0] MTIMER_MTIME_HI = 3'd1;
  localparam logic [2:0] MTIMER_CMP_LO   = 3'd2;
  localparam logic [2:0] MTIMER_CMP_HI   = 3'd3;
  localparam logic [2:0] MTIMER_MSIP     = 3'd4;

  // Bus handshake states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } mtimer_state_t;

  // Replace the bytes of old_val selected by mask with the bytes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kronos_bus_responder.sv
// Generic Kronos data-bus responder: request/wait/ack handshake with
// optional wait states. Emits a read strobe on the cycle before ack (so the
// peripheral can register read data) and a write strobe during the ack cycle.
module kronos_bus_responder
  import kronos_types::*;
#(
  parameter logic [31:0] WAIT_STATES = 32'd0
) (
  input  logic clk,
  input  logic rstz,
  input  logic req_i,
  input  logic wr_en_i,
  output logic ack_o,
  output logic rd_strobe_o,
  output logic wr_strobe_o
);

  mtimer_state_t state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;

  // Next-state and wait-counter logic
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d   = WAIT_STATES;
          state_d = (WAIT_STATES == 32'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
          if (cnt_d == 32'd0) state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o       = (state_q == ACK);
  assign rd_strobe_o = (state_d == ACK) && (state_q != ACK) && !wr_en_i;
  assign wr_strobe_o = (state_q == ACK) && wr_en_i;

endmodule

// File: rtl/kronos_mtimer_slave.sv
// RISC-V machine timer (mtime/mtimecmp) and msip as a Kronos data-bus target.
module kronos_mtimer_slave
  import kronos_types::*;
#(
  parameter logic [31:0] PRESCALE    = 32'd1,
  parameter logic [31:0] WAIT_STATES = 32'd0
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  logic [2:0]  reg_off;
  logic        unused_addr_bits;
  logic        rd_strobe, wr_strobe;
  logic [31:0] rd_mux;
  logic        tick;
  logic [31:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q;
  logic [31:0] rd_data_q;

  assign reg_off          = data_addr[4:2];
  assign unused_addr_bits = ^{data_addr[31:5], data_addr[1:0]};

  kronos_bus_responder #(
    .WAIT_STATES(WAIT_STATES)
  ) u_responder (
    .clk        (clk),
    .rstz       (rstz),
    .req_i      (data_req),
    .wr_en_i    (data_wr_en),
    .ack_o      (data_ack),
    .rd_strobe_o(rd_strobe),
    .wr_strobe_o(wr_strobe)
  );

  // Read data mux over the register map; unmapped offsets read 0
  always_comb begin
    rd_mux = '0;
    case (reg_off)
      MTIMER_MTIME_LO: rd_mux = mtime_q[31:0];
      MTIMER_MTIME_HI: rd_mux = mtime_q[63:32];
      MTIMER_CMP_LO:   rd_mux = mtimecmp_q[31:0];
      MTIMER_CMP_HI:   rd_mux = mtimecmp_q[63:32];
      MTIMER_MSIP:     rd_mux = {31'd0, msip_q};
      default:         rd_mux = '0;
    endcase
  end

  assign tick    = (presc_q == PRESCALE - 32'd1);
  assign presc_d = tick ? '0 : presc_q + 32'd1;

  // Register updates: tick increments mtime unless a write to mtime wins
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_strobe) begin
      case (reg_off)
        MTIMER_MTIME_LO:
          if (data_mask != 4'h0)
            mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], data_wr_data, data_mask)};
        MTIMER_MTIME_HI:
          if (data_mask != 4'h0)
            mtime_d = {byte_merge(mtime_q[63:32], data_wr_data, data_mask), mtime_q[31:0]};
        MTIMER_CMP_LO:
          mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], data_wr_data, data_mask);
        MTIMER_CMP_HI:
          mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], data_wr_data, data_mask);
        MTIMER_MSIP:
          if (data_mask[0]) msip_d = data_wr_data[0];
        default: ;
      endcase
    end
  end

  // Timer state, registered read data and registered compare
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      rd_data_q   <= rd_strobe ? rd_mux : '0;
    end
  end

  assign data_rd_data       = rd_data_q;
  assign timer_interrupt    = timer_irq_q;
  assign software_interrupt = msip_q;

endmodule
